// File: rtl/spram_pipe_wrapper.sv
// spram_pipe_wrapper: single-port RAM with a valid/ready request port,
// byte-masked writes, an N_DELAY-cycle read pipeline and a credit-limited
// show-ahead response FIFO, so read data is never dropped under backpressure.
// Optional feature: define SPRAM_PARITY_EN to keep one even-parity bit per
// byte, corrupt it on demand via perr_inj, and flag bad reads on rsp_perr.

module spram_pipe_wrapper #(
  parameter int DW        = 64,
  parameter int AW        = 8,
  parameter int DEPTH     = 256,
  parameter int N_DELAY   = 1,
  parameter int BE_W      = DW / 8,
  parameter int RSP_DEPTH = N_DELAY + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [BE_W-1:0] req_be,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic            perr_inj,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_perr,
  output logic            busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
`ifdef SPRAM_PARITY_EN
  localparam int EW = DW + BE_W;
`else
  localparam int EW = DW;
`endif
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CREDITS  = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  // Storage word: data bytes, plus parity bits above them when enabled
  logic [EW-1:0] mem [DEPTH];

  logic          addr_ok;
  logic          rd_acc;
  logic          wr_acc;
  logic          pop;
  logic [EW-1:0] mem_rd;
  logic          push_vld;
  logic [EW-1:0] push_ext;

  logic [DW-1:0] fifo_data [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_d, fifo_cnt_q;
  logic [CW-1:0] cnt_d, cnt_q;

`ifdef SPRAM_PARITY_EN
  logic                 push_perr;
  logic [RSP_DEPTH-1:0] fifo_perr;
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
`endif

  // Reads and writes share one credit gate; reads hold a credit until popped
  assign req_ready = !rst && (cnt_q < CREDITS);
  assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);
  assign wr_acc    = req_valid && req_ready && req_we;
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (cnt_q != '0);

  // Byte-masked write; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (wr_acc && addr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
`ifdef SPRAM_PARITY_EN
          mem[req_addr][DW+i] <= (^req_wdata[i*8 +: 8]) ^ perr_inj;
`endif
        end
      end
    end
  end

  // Memory sample taken at the acceptance edge; out-of-range reads give zero
  always_comb begin
    mem_rd = '0;
    if (addr_ok) begin
      mem_rd = mem[req_addr];
    end
  end

  generate
    if (N_DELAY == 1) begin : g_direct
      assign push_vld = rd_acc;
      assign push_ext = mem_rd;
    end else begin : g_pipe
      localparam int NS = N_DELAY - 1;
      logic [NS-1:0] st_vld_d, st_vld_q;
      logic [EW-1:0] st_ext_d [NS];
      logic [EW-1:0] st_ext_q [NS];

      // Shift the read sample through the extra latency stages
      always_comb begin
        st_vld_d[0] = rd_acc;
        st_ext_d[0] = mem_rd;
        for (int k = 1; k < NS; k++) begin
          st_vld_d[k] = st_vld_q[k-1];
          st_ext_d[k] = st_ext_q[k-1];
        end
      end

      // Stage registers; valid bits are cleared so reset discards in-flight reads
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_vld_q <= '0;
          st_ext_q <= '{default: '0};
        end else begin
          st_vld_q <= st_vld_d;
          st_ext_q <= st_ext_d;
        end
      end

      assign push_vld = st_vld_q[NS-1];
      assign push_ext = st_ext_q[NS-1];
    end
  endgenerate

`ifdef SPRAM_PARITY_EN
  // Recompute even parity of each byte as it enters the FIFO
  always_comb begin
    push_perr = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      push_perr = push_perr | ((^push_ext[i*8 +: 8]) != push_ext[DW+i]);
    end
  end
`endif

  // FIFO storage is written on push and needs no reset
  always_ff @(posedge clk) begin
    if (push_vld) begin
      fifo_data[wr_ptr_q] <= push_ext[DW-1:0];
`ifdef SPRAM_PARITY_EN
      fifo_perr[wr_ptr_q] <= push_perr;
`endif
    end
  end

  // Pointer wrap, FIFO occupancy and outstanding-read credit bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    cnt_d      = cnt_q;
    if (push_vld) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push_vld, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({rd_acc, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset empties the FIFO and returns all credits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Show-ahead head of the FIFO, forced to zero while empty
  always_comb begin
    rsp_rdata = '0;
    rsp_perr  = 1'b0;
    if (rsp_valid) begin
      rsp_rdata = fifo_data[rd_ptr_q];
`ifdef SPRAM_PARITY_EN
      rsp_perr  = fifo_perr[rd_ptr_q];
`endif
    end
  end

  // Credits guarantee the FIFO has room whenever the pipeline delivers data
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push_vld && (fifo_cnt_q == CREDITS)));

endmodule

// File: tb/tb_spram_pipe_wrapper.sv
// Testbench for spram_pipe_wrapper: drives requests, keeps a reference model of
// the memory and parity state, and scores every response in order.
// Honours SPRAM_PARITY_EN for the expected rsp_perr values.

module tb_spram_pipe_wrapper;

  localparam int DW        = 64;
  localparam int AW        = 8;
  localparam int DEPTH     = 200;
  localparam int N_DELAY   = 3;
  localparam int BE_W      = 8;
  localparam int RSP_DEPTH = N_DELAY + 1;
`ifdef SPRAM_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        perr;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [BE_W-1:0] req_be;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            perr_inj;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_perr;
  logic            busy;

  rsp_t        exp_q[$];
  logic [63:0] model_mem  [256];
  logic [7:0]  model_pbad [256];
  int          errors = 0;
  int          checks = 0;
  int          hs_count = 0;

  spram_pipe_wrapper #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .N_DELAY(N_DELAY),
    .BE_W(BE_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .perr_inj(perr_inj),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_perr(rsp_perr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic rsp_t expectedRead(input logic [7:0] addr);
    rsp_t r;
    r.data = '0;
    r.perr = 1'b0;
    if (int'(addr) < DEPTH) begin
      r.data = model_mem[addr];
      r.perr = PARITY_EN && (model_pbad[addr] != 8'h00);
    end
    return r;
  endfunction

  task automatic modelWrite(input logic [7:0] addr, input logic [7:0] be, input logic [63:0] wdata, input logic inj);
    if (int'(addr) < DEPTH) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) begin
          model_mem[addr][i*8 +: 8] = wdata[i*8 +: 8];
          model_pbad[addr][i]       = inj;
        end
      end
    end
  endtask

  // One request: hold it until accepted, update model / scoreboard, return #1 after the edge
  task automatic applyStimulus(input logic we, input logic [7:0] be, input logic [7:0] addr,
                               input logic [63:0] wdata, input logic inj);
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    perr_inj  = inj;
    @(negedge clk);
    while (!req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checkOutput("req_accept_timeout", req_ready, 1);
    end else begin
      if (!we) exp_q.push_back(expectedRead(addr));
      @(posedge clk);
      if (we) modelWrite(addr, be, wdata, inj);
      #1;
    end
    req_valid = 1'b0;
    perr_inj  = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", rsp_valid, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.data);
        checkOutput("rsp_perr", rsp_perr, e.perr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int accepted;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    perr_inj  = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      model_mem[i]  = '0;
      model_pbad[i] = '0;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_perr", rsp_perr, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", req_ready, 1);
    @(posedge clk);
    #1;

    // Preload addresses 0..5 and 0x20..0x2F
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 8'hFF, 8'(i), 64'hA5A5_0000_0000_0000 | 64'(i), 1'b0);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 8'hFF, 8'(8'h20 + i), 64'h0101_0101_0101_0101 * 64'(i + 3), 1'b0);

    $display("[TB] write/read latency");
    applyStimulus(1'b1, 8'hFF, 8'h05, 64'h1122_3344_5566_7788, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h05, 64'h0, 1'b0);
    lat = 0;
    for (int k = 1; k <= N_DELAY + 3; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("read_latency", 64'(lat), 64'(N_DELAY));
    checkOutput("latency_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
    waitDrain(20);

    $display("[TB] byte enables and read-after-write");
    applyStimulus(1'b1, 8'hFF, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 8'h0F, 8'h10, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h10, 64'h0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h10, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h10, 64'h0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h11, 64'h0123_4567_89AB_CDEF, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h11, 64'h0, 1'b0);
    waitDrain(40);

    $display("[TB] out-of-range addresses");
    applyStimulus(1'b1, 8'hFF, 8'hC7, 64'hCAFE_F00D_1234_5678, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'hC8, 64'h5555_AAAA_5555_AAAA, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'hC7, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'hC8, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'hFF, 64'h0, 1'b0);
    waitDrain(40);
    checkOutput("oor_busy_clear", busy, 0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 10; c++) begin
      if (accepted < 6) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'(accepted);
      end
      @(negedge clk);
      if (req_ready && accepted < 6) begin
        exp_q.push_back(expectedRead(8'(accepted)));
        @(posedge clk);
        #1;
        accepted++;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    checkOutput("bp_accepted", 64'(accepted), 4);
    checkOutput("bp_req_ready", req_ready, 0);
    checkOutput("bp_busy", busy, 1);
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    checkOutput("bp_head_rdata", rsp_rdata, 64'hA5A5_0000_0000_0000);
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h04, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h05, 64'h0, 1'b0);
    waitDrain(40);
    checkOutput("bp_ready_restored", req_ready, 1);

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'(8'h20 + i);
      @(negedge clk);
      checkOutput("b2b_req_ready", req_ready, 1);
      checkOutput("b2b_rsp_valid", rsp_valid, 64'(i >= N_DELAY));
      if (req_ready) exp_q.push_back(expectedRead(8'(8'h20 + i)));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    waitDrain(40);

    $display("[TB] parity injection");
    applyStimulus(1'b1, 8'hFF, 8'h30, 64'h0F0F_1234_5678_9ABC, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h30, 64'h0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'h30, 64'h0F0F_1234_5678_9ABC, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h30, 64'h0, 1'b0);
    applyStimulus(1'b1, 8'h02, 8'h31, 64'h0000_0000_0000_7700, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h31, 64'h0, 1'b0);
    waitDrain(40);

    $display("[TB] reset with reads in flight");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h21, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h22, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre_rst_rsp_valid", rsp_valid, 1);
    checkOutput("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_req_ready", req_ready, 0);
    checkOutput("mid_rst_rsp_rdata", rsp_rdata, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rerelease_req_ready", req_ready, 1);
    rsp_ready = 1'b1;
    lat = hs_count;
    repeat (10) @(negedge clk);
    checkOutput("no_stale_rsp", 64'(hs_count - lat), 0);
    checkOutput("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 8'h21, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h22, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h05, 64'h0, 1'b0);
    waitDrain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spram_pipe_wrapper.md
Name: spram_pipe_wrapper

Overview:
- Parametrised single-port RAM block with a valid/ready request port and a valid/ready response port.
- Adds per-byte write enables, a configurable read pipeline latency (N_DELAY), and a credit-controlled response FIFO, so read data is never lost under response backpressure.
- Sits between DMA or buffer-control logic and the on-chip weight, feature and scale buffers.
- Uses a behavioural memory array.

Parameters:
- DW, 64, data bits per word; must be a multiple of 8.
- AW, 8, address bits.
- DEPTH, 256, number of words; DEPTH <= 2^AW.
- N_DELAY, 1, read latency from request acceptance to data entering the response FIFO; legal range 1..4.
- BE_W, DW/8, number of byte-enable bits.
- RSP_DEPTH, N_DELAY+1, response FIFO depth and read-credit limit; must be >= N_DELAY+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = write request, 0 = read request.
- req_be  in  BE_W  byte enables; write requests only.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- perr_inj  in  1  parity-error injection; used only with the optional feature.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the read data.
- rsp_rdata  out  DW  read data (show-ahead FIFO head).
- rsp_perr  out  1  parity error on the current response.
- busy  out  1  reads are in flight or queued.

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high.
- Reset values:
  - req_ready=0 while rst is high, 1 on the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_perr=0, busy=0.
  - Pipeline valid bits cleared, FIFO pointers and counters 0.
  - Memory contents are not reset.
- Acceptance: a request is accepted on a clk edge where req_valid and req_ready are both high.
- Credit counter cnt (width clog2(RSP_DEPTH+1)):
  - Counts reads in the pipeline plus FIFO entries.
  - +1 on an accepted read; -1 on a response handshake (rsp_valid and rsp_ready).
  - Both in the same cycle: no change.
- req_ready = !rst_state and (cnt < RSP_DEPTH).
  - Applies to reads and writes alike; it does not depend on req_we.
- Write handling:
  - For each byte i with req_be[i]=1, mem[addr] byte i takes wdata byte i at the acceptance edge.
  - Writes produce no response and take no credit.
  - A write with req_be=0 is accepted and is a no-op.
- Read handling:
  - The memory is sampled at the acceptance edge.
  - Data then passes through N_DELAY-1 further pipeline register stages, then is pushed into the FIFO.
  - With the FIFO empty, rsp_valid rises exactly N_DELAY cycles after the acceptance edge. For N_DELAY=1 it is valid in the cycle after acceptance.
- Throughput: with rsp_ready held high, one read per cycle is sustained indefinitely.
- Ordering: responses return in request order.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data.
- Out-of-range address (addr >= DEPTH): writes are ignored; reads return 0 with rsp_perr=0 and still consume and return a credit.
- FIFO:
  - Push and pop in the same cycle are both performed.
  - Overflow cannot occur by construction. Verification asserts no push while full.
- busy = (cnt != 0).
- Mid-operation reset: in-flight and queued reads are discarded and no response is produced for them.

Optional Feature:
- Macro: SPRAM_PARITY_EN.
- Defined:
  - Memory stores BE_W extra even-parity bits, one per byte, updated with that byte's write enable.
  - If perr_inj=1 at a write acceptance, the written bytes' parity bits are stored inverted.
  - On a read, parity is recomputed at FIFO push. rsp_perr=1 if any byte mismatches, and travels with its rsp_rdata entry.
- Undefined: no parity storage, perr_inj is ignored, rsp_perr is tied to 0.

Test Plan:
- Reset then write addr 0x05 = 0x1122334455667788 with be=0xFF, then read 0x05 -> rsp_valid rises N_DELAY cycles after acceptance with rsp_rdata=0x1122334455667788.
- Write 0xFFFF_FFFF_FFFF_FFFF to addr 0x10, then write 0 with be=0x0F, then read 0x10 -> 0xFFFFFFFF00000000.
- N_DELAY=3, rsp_ready=0, issue 6 reads to addresses 0..5 -> exactly 4 accepted and req_ready=0. Then raise rsp_ready -> data for addresses 0..5 returned in order with no loss.
- rsp_ready=1, 16 back-to-back reads -> req_ready stays 1 and one response per cycle after N_DELAY cycles.
- Assert rst while 2 reads are in flight -> rsp_valid=0 and busy=0 immediately. After release, no stale responses appear and memory data is retained.
- With SPRAM_PARITY_EN defined: write with perr_inj=1, then read -> rsp_perr=1. Rewrite with perr_inj=0, then read -> rsp_perr=0.
